fsm_dec: RTL and testbench
==========================

# fsm_dec

Symbol-stream decoder for the 4-state Mealy encoder FSM used in the lab FSM designs. It consumes the encoder's 2-bit output symbols, tracks the encoder's state in lock-step, and recovers the original serial input bits. It flags symbols the encoder can never emit from the current state, keeps a short history of recovered bits, and drives two 7-segment digits showing the tracked state and the error count. It sits at the receiving end of the encoder's `o` bus.

## Interface
- `HIST_W`, default 8: width of the recovered-bit history register.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sym_valid` input 1: `sym` is valid this cycle; at most one symbol is consumed per cycle.
- `sym` input 2: encoder output symbol, values 0..3.
- `bit_out` output 1: last recovered input bit.
- `bit_valid` output 1: one-cycle pulse; `bit_out` was updated at this edge.
- `err` output 1: one-cycle pulse; an illegal symbol was consumed at this edge.
- `state` output 2: tracked encoder state, S0=0 .. S3=3.
- `hist` output HIST_W: recovered bits, newest in bit 0.
- `err_cnt` output 4: saturating illegal-symbol count.
- `seg_state` output 7: 7-segment pattern of `state`, from the team hex decoder.
- `seg_err` output 7: 7-segment pattern of `err_cnt`, hex 0..F.

## Operation
- Decode table, by state: symbol -> recovered bit, next state.
  - S0: 1 -> bit 1, S1. 0 -> bit 0, S0.
  - S1: 2 -> bit 1, S3. 0 -> bit 0, S2.
  - S2: 0 -> bit 1, S3. 1 -> bit 0, S2.
  - S3: 0 -> bit 1, S0. 1 -> bit 0, S1.
- Any other symbol/state pair is illegal:
  - sym 3 in any state;
  - sym 2 in S0, S2 or S3;
  - sym 1 in S1.
- Legal symbol consumed:
  - `state` <= next state;
  - `bit_out` <= recovered bit;
  - `bit_valid` = 1;
  - `hist` <= {hist[HIST_W-2:0], bit}.
- Illegal symbol consumed:
  - `state`, `bit_out` and `hist` unchanged;
  - `err` = 1;
  - `err_cnt` increments and saturates at 15 (no wrap).
- `sym_valid`=0: nothing changes; `bit_valid` and `err` are 0.
- `bit_valid` and `err` are mutually exclusive and never both 1.
- `seg_state` and `seg_err` are combinational decodes of the `state` and `err_cnt` registers.

## Timing
- Reset (`rst`=0, asynchronous, at any time including mid-stream) forces:
  - `state`=S0, `bit_out`=0, `bit_valid`=0, `err`=0;
  - `hist`=0, `err_cnt`=0.
  - `seg_state` and `seg_err` then show the digit 0.
- Reset release is synchronous to `clk`. The first symbol is sampled at the first rising edge with `rst`=1.
- Latency is one cycle. A symbol sampled at edge N updates all registered outputs at edge N, and they are visible during the cycle after N.
- `bit_valid` and `err` are high for exactly one cycle per consumed symbol. Back-to-back `sym_valid` gives back-to-back pulses.
- `err_cnt` at 15 plus an illegal symbol: `err` still pulses; `err_cnt` stays 15.
- `hist` keeps only the last HIST_W bits; older bits shift out of the MSB.
- No handshake back-pressure: the block accepts every valid symbol.

## Test plan
- Reset, then stream 1,2,0,0 with `sym_valid`=1 for 4 cycles:
  - `bit_valid` pulses 4 times, bits 1,1,1,0;
  - `state` goes S1,S3,S0,S0;
  - `hist`=8'h0E, `err`=0 throughout.
- Reset, then 1,0,1,0,1 (inputs 1,0,0,1,0 via S1,S2,S2,S3,S1):
  - bits 1,0,0,1,0;
  - final `state`=S1, `hist`=8'h12, `seg_state` shows 1.
- In S0 send 2, then 3:
  - `err` pulses twice, `state` stays S0, `hist` unchanged;
  - `err_cnt`=2, `seg_err` shows 2.
- Send 17 illegal symbols (sym 3):
  - `err_cnt` reaches 15 and stays 15;
  - `seg_err` shows F; `err` pulses all 17 times.
- `sym_valid`=0 for 5 cycles with garbage on `sym`: no pulses; `state`, `hist` and `err_cnt` are unchanged.
- Mid-stream in S3 with `err_cnt`=3, assert `rst` between clock edges:
  - all outputs go to reset values immediately;
  - the next sym 1 after release decodes from S0 to bit 1, S1.

Source files
------------

// File: rtl/fsm_dec.sv
// -----------------------------------------------------------------------------
// fsm_dec
//
// Symbol-stream decoder for the lab's 4-state Mealy encoder. It follows the
// encoder's state in lock-step from the 2-bit symbols it receives, recovers
// the original serial input bits, and flags symbols that the encoder cannot
// emit from the tracked state. It keeps a short history of recovered bits and
// drives two 7-segment digits for the tracked state and the error count.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous active-low reset
//   sym_valid  in   1       sym is valid this cycle (one symbol per cycle)
//   sym        in   2       encoder output symbol
//   bit_out    out  1       last recovered bit
//   bit_valid  out  1       one-cycle pulse: bit_out updated at this edge
//   err        out  1       one-cycle pulse: illegal symbol consumed
//   state      out  2       tracked encoder state (S0..S3)
//   hist       out  HIST_W  recovered bits, newest in bit 0
//   err_cnt    out  4       saturating illegal-symbol count
//   seg_state  out  7       7-segment pattern of state   ({g,f,e,d,c,b,a})
//   seg_err    out  7       7-segment pattern of err_cnt ({g,f,e,d,c,b,a})
// -----------------------------------------------------------------------------
module fsm_dec #(
    parameter int HIST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    input  logic [1:0]        sym,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              err,
    output logic [1:0]        state,
    output logic [HIST_W-1:0] hist,
    output logic [3:0]        err_cnt,
    output logic [6:0]        seg_state,
    output logic [6:0]        seg_err
);

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    // Team hex digit decoder, active-high segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [1:0]        r_state;
    logic              r_bit_out;
    logic              r_bit_valid;
    logic              r_err;
    logic [HIST_W-1:0] r_hist;
    logic [3:0]        r_err_cnt;

    logic              w_legal;
    logic              w_bit;
    logic [1:0]        w_dec_next;
    logic [1:0]        w_next_state;
    logic              w_take;
    logic              w_reject;
    logic [6:0]        w_seg_state;
    logic [6:0]        w_seg_err;

    // Next-state logic: inverse of the encoder's Mealy table.
    always_comb begin
        w_legal    = 1'b0;
        w_bit      = 1'b0;
        w_dec_next = r_state;
        case (r_state)
            S0: begin
                if (sym == 2'd1) begin
                    w_legal = 1'b1; w_bit = 1'b1; w_dec_next = S1;
                end else if (sym == 2'd0) begin
                    w_legal = 1'b1; w_bit = 1'b0; w_dec_next = S0;
                end else begin
                    w_legal = 1'b0; w_bit = 1'b0; w_dec_next = r_state;
                end
            end
            S1: begin
                if (sym == 2'd2) begin
                    w_legal = 1'b1; w_bit = 1'b1; w_dec_next = S3;
                end else if (sym == 2'd0) begin
                    w_legal = 1'b1; w_bit = 1'b0; w_dec_next = S2;
                end else begin
                    w_legal = 1'b0; w_bit = 1'b0; w_dec_next = r_state;
                end
            end
            S2: begin
                if (sym == 2'd0) begin
                    w_legal = 1'b1; w_bit = 1'b1; w_dec_next = S3;
                end else if (sym == 2'd1) begin
                    w_legal = 1'b1; w_bit = 1'b0; w_dec_next = S2;
                end else begin
                    w_legal = 1'b0; w_bit = 1'b0; w_dec_next = r_state;
                end
            end
            S3: begin
                if (sym == 2'd0) begin
                    w_legal = 1'b1; w_bit = 1'b1; w_dec_next = S0;
                end else if (sym == 2'd1) begin
                    w_legal = 1'b1; w_bit = 1'b0; w_dec_next = S1;
                end else begin
                    w_legal = 1'b0; w_bit = 1'b0; w_dec_next = r_state;
                end
            end
            default: begin
                w_legal    = 1'b0;
                w_bit      = 1'b0;
                w_dec_next = S0;
            end
        endcase

        w_take   = sym_valid & w_legal;
        w_reject = sym_valid & ~w_legal;

        if (w_take) begin
            w_next_state = w_dec_next;
        end else begin
            w_next_state = r_state;
        end
    end

    // Tracked encoder state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Recovered bit, history, pulses and saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_err       <= 1'b0;
            r_hist      <= '0;
            r_err_cnt   <= 4'd0;
        end else begin
            r_bit_valid <= w_take;
            r_err       <= w_reject;
            if (w_take) begin
                r_bit_out <= w_bit;
                r_hist    <= {r_hist[HIST_W-2:0], w_bit};
            end
            // Counter holds at 15 rather than wrapping so a flood of bad
            // symbols cannot make the display look healthy again.
            if (w_reject && (r_err_cnt != 4'd15)) begin
                r_err_cnt <= r_err_cnt + 4'd1;
            end
        end
    end

    // Output decode: display digits from the registered state and count.
    always_comb begin
        w_seg_state = hex_to_seg({2'b00, r_state});
        w_seg_err   = hex_to_seg(r_err_cnt);
    end

    assign state     = r_state;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign err       = r_err;
    assign hist      = r_hist;
    assign err_cnt   = r_err_cnt;
    assign seg_state = w_seg_state;
    assign seg_err   = w_seg_err;

endmodule

// File: tb/tb_fsm_dec.sv
// -----------------------------------------------------------------------------
// tb_fsm_dec
//
// Directed bench for fsm_dec. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge that consumed the symbol.
// -----------------------------------------------------------------------------
module tb_fsm_dec;

    logic       clk;
    logic       rst;
    logic       sym_valid;
    logic [1:0] sym;
    logic       bit_out;
    logic       bit_valid;
    logic       err;
    logic [1:0] state;
    logic [7:0] hist;
    logic [3:0] err_cnt;
    logic [6:0] seg_state;
    logic [6:0] seg_err;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_dec #(.HIST_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym       (sym),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .err       (err),
        .state     (state),
        .hist      (hist),
        .err_cnt   (err_cnt),
        .seg_state (seg_state),
        .seg_err   (seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one symbol for one cycle and wait until its result is visible.
    task automatic send(input logic v, input logic [1:0] s);
        @(negedge clk);
        sym_valid = v;
        sym       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sym_valid = 1'b0;
        sym       = 2'd0;
        rst       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({state, bit_out, bit_valid, err, hist, err_cnt} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got state=%0d bit=%0b bv=%0b err=%0b hist=%h cnt=%0d, need all 0",
                     state, bit_out, bit_valid, err, hist, err_cnt);
        end
        n_tests++;
        if (seg_state !== 7'h3F || seg_err !== 7'h3F) begin
            n_fail++;
            $display("FAIL reset_seg: got seg_state=%h seg_err=%h, need 3f 3f", seg_state, seg_err);
        end
    endtask

    task automatic test_stream_a();
        logic [1:0] syms [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
        logic       bits [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] sts  [4] = '{2'd1, 2'd3, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, syms[i]);
            n_tests++;
            if (bit_valid !== 1'b1 || err !== 1'b0 || bit_out !== bits[i] || state !== sts[i]) begin
                n_fail++;
                $display("FAIL stream_a step %0d: got bv=%0b err=%0b bit=%0b state=%0d, need 1 0 %0b %0d",
                         i, bit_valid, err, bit_out, state, bits[i], sts[i]);
            end
        end
        n_tests++;
        if (hist !== 8'h0E) begin
            n_fail++;
            $display("FAIL stream_a hist: got %h, need 0e", hist);
        end
    endtask

    task automatic test_stream_b();
        logic [1:0] syms [5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        logic       bits [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] sts  [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, syms[i]);
            n_tests++;
            if (bit_valid !== 1'b1 || err !== 1'b0 || bit_out !== bits[i] || state !== sts[i]) begin
                n_fail++;
                $display("FAIL stream_b step %0d: got bv=%0b err=%0b bit=%0b state=%0d, need 1 0 %0b %0d",
                         i, bit_valid, err, bit_out, state, bits[i], sts[i]);
            end
        end
        n_tests++;
        if (hist !== 8'h12 || seg_state !== 7'h06) begin
            n_fail++;
            $display("FAIL stream_b final: got hist=%h seg_state=%h, need 12 06", hist, seg_state);
        end
    endtask

    // Continues from S1/hist=12: walk to S0 with bits 0,1,1 -> hist 93.
    task automatic test_illegal();
        logic [1:0] bad [2] = '{2'd2, 2'd3};
        send(1'b1, 2'd0);
        send(1'b1, 2'd0);
        send(1'b1, 2'd0);
        n_tests++;
        if (state !== 2'd0 || hist !== 8'h93 || bit_out !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_setup: got state=%0d hist=%h bit=%0b, need 0 93 1", state, hist, bit_out);
        end
        for (int i = 0; i < 2; i++) begin
            send(1'b1, bad[i]);
            n_tests++;
            if (err !== 1'b1 || bit_valid !== 1'b0 || state !== 2'd0 || hist !== 8'h93 ||
                bit_out !== 1'b1 || err_cnt !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL illegal step %0d: got err=%0b bv=%0b state=%0d hist=%h bit=%0b cnt=%0d, need 1 0 0 93 1 %0d",
                         i, err, bit_valid, state, hist, bit_out, err_cnt, i + 1);
            end
        end
        n_tests++;
        if (seg_err !== 7'h5B) begin
            n_fail++;
            $display("FAIL illegal_seg: got seg_err=%h, need 5b", seg_err);
        end
    endtask

    // Starts from err_cnt=2; 17 more illegal symbols must pin the count at 15.
    task automatic test_saturate();
        int exp_cnt;
        for (int i = 0; i < 17; i++) begin
            send(1'b1, 2'd3);
            exp_cnt = (3 + i > 15) ? 15 : 3 + i;
            n_tests++;
            if (err !== 1'b1 || bit_valid !== 1'b0 || err_cnt !== 4'(exp_cnt)) begin
                n_fail++;
                $display("FAIL saturate step %0d: got err=%0b bv=%0b cnt=%0d, need 1 0 %0d",
                         i, err, bit_valid, err_cnt, exp_cnt);
            end
        end
        n_tests++;
        if (seg_err !== 7'h71 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL saturate_final: got seg_err=%h state=%0d, need 71 0", seg_err, state);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 2'($urandom_range(0, 3)));
            n_tests++;
            if (bit_valid !== 1'b0 || err !== 1'b0 || state !== 2'd0 || hist !== 8'h93 || err_cnt !== 4'd15) begin
                n_fail++;
                $display("FAIL idle step %0d: got bv=%0b err=%0b state=%0d hist=%h cnt=%0d, need 0 0 0 93 15",
                         i, bit_valid, err, state, hist, err_cnt);
            end
        end
    endtask

    // Legal / illegal / legal with no idle cycle between them.
    task automatic test_back_to_back();
        logic [1:0] syms [3] = '{2'd1, 2'd1, 2'd2};
        logic       bvs  [3] = '{1'b1, 1'b0, 1'b1};
        logic       errs [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0] sts  [3] = '{2'd1, 2'd1, 2'd3};
        logic [7:0] hs   [3] = '{8'h27, 8'h27, 8'h4F};
        for (int i = 0; i < 3; i++) begin
            send(1'b1, syms[i]);
            n_tests++;
            if (bit_valid !== bvs[i] || err !== errs[i] || state !== sts[i] || hist !== hs[i] || err_cnt !== 4'd15) begin
                n_fail++;
                $display("FAIL b2b step %0d: got bv=%0b err=%0b state=%0d hist=%h cnt=%0d, need %0b %0b %0d %h 15",
                         i, bit_valid, err, state, hist, err_cnt, bvs[i], errs[i], sts[i], hs[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(1'b1, 2'd3);
        send(1'b1, 2'd3);
        send(1'b1, 2'd3);
        send(1'b1, 2'd1);
        send(1'b1, 2'd2);
        n_tests++;
        if (state !== 2'd3 || err_cnt !== 4'd3 || hist !== 8'h03) begin
            n_fail++;
            $display("FAIL arst_setup: got state=%0d cnt=%0d hist=%h, need 3 3 03", state, err_cnt, hist);
        end
        // Drop reset between edges; outputs must clear without a clock.
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({state, bit_out, bit_valid, err, hist, err_cnt} !== 17'd0 ||
            seg_state !== 7'h3F || seg_err !== 7'h3F) begin
            n_fail++;
            $display("FAIL arst_clear: got state=%0d bit=%0b bv=%0b err=%0b hist=%h cnt=%0d seg=%h/%h, need zeros 3f/3f",
                     state, bit_out, bit_valid, err, hist, err_cnt, seg_state, seg_err);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send(1'b1, 2'd1);
        n_tests++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b1 || state !== 2'd1 || hist !== 8'h01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_resume: got bv=%0b bit=%0b state=%0d hist=%h err=%0b, need 1 1 1 01 0",
                     bit_valid, bit_out, state, hist, err);
        end
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        sym_valid = 1'b0;
        sym       = 2'd0;
        test_reset();
        test_stream_a();
        test_stream_b();
        test_illegal();
        test_saturate();
        test_idle();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
